// File: rtl/mem_arb_if.sv
// Bus bundle between the two requesters (CPU, DMA), the arbiter and the memory
// controller. The arbiter side uses the slave modport; the requesters and the
// controller model use the master modport.
interface mem_arb_if;
    // requester side
    logic        cpu_req;
    logic        dma_req;
    logic        cpu_we;
    logic        dma_we;
    logic [15:0] cpu_addr;
    logic [15:0] dma_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  dma_wdata;
    logic        cpu_ack;
    logic        dma_ack;
    logic        cpu_err;
    logic        dma_err;
    logic [7:0]  cpu_rdata;
    logic [7:0]  dma_rdata;
    // memory controller side
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        mem_busy;
    logic [7:0]  mem_rdata;
    // current owner, one-hot {dma,cpu}
    logic [1:0]  grant;

    modport slave (
        input  cpu_req, dma_req, cpu_we, dma_we, cpu_addr, dma_addr,
        input  cpu_wdata, dma_wdata, mem_busy, mem_rdata,
        output cpu_ack, dma_ack, cpu_err, dma_err, cpu_rdata, dma_rdata,
        output mem_addr, mem_wdata, mem_read_en, mem_write_en, grant
    );

    modport master (
        output cpu_req, dma_req, cpu_we, dma_we, cpu_addr, dma_addr,
        output cpu_wdata, dma_wdata, mem_busy, mem_rdata,
        input  cpu_ack, dma_ack, cpu_err, dma_err, cpu_rdata, dma_rdata,
        input  mem_addr, mem_wdata, mem_read_en, mem_write_en, grant
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: two-requester (CPU/DMA) arbiter in front of a single memory
// controller. One transaction at a time: IDLE -> ISSUE (one-cycle strobe) ->
// WAIT (until mem_busy drops or TIMEOUT busy cycles elapse) -> ACK.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate simultaneous
// requests; otherwise the CPU always wins a tie.
module mem_arb #(
    parameter int unsigned TIMEOUT = 255   // 1..255 busy WAIT cycles before abort
) (
    input logic     clk,
    input logic     reset,                 // asynchronous, active low
    mem_arb_if.slave bus
);

    localparam logic [3:0] IDLE  = 4'b0001;
    localparam logic [3:0] ISSUE = 4'b0010;
    localparam logic [3:0] WAIT  = 4'b0100;
    localparam logic [3:0] ACK   = 4'b1000;

    localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT);

    logic [3:0]  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        read_en_q, read_en_d;
    logic        write_en_q, write_en_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dma_ack_q, dma_ack_d;
    logic        cpu_err_q, cpu_err_d;
    logic        dma_err_q, dma_err_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;

    logic        win_dma;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        prio_q, prio_d;           // 1 = DMA favoured on the next tie
`endif

    // Pick the winner among the current requesters and mux its command
    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (bus.cpu_req && bus.dma_req) begin
            win_dma = prio_q;
        end else begin
            win_dma = bus.dma_req;
        end
`else
        win_dma = bus.dma_req && !bus.cpu_req;
`endif
        sel_we    = win_dma ? bus.dma_we    : bus.cpu_we;
        sel_addr  = win_dma ? bus.dma_addr  : bus.cpu_addr;
        sel_wdata = win_dma ? bus.dma_wdata : bus.cpu_wdata;
    end

    assign cnt_inc = cnt_q + 8'd1;

    // Transaction FSM next-state; strobes, acks and errs are single-cycle pulses
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        read_en_d   = 1'b0;
        write_en_d  = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        dma_err_d   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prio_d      = prio_q;
`endif
        case (state_q)
            IDLE: begin
                // a busy controller (e.g. self-test) blocks any new issue
                if ((bus.cpu_req || bus.dma_req) && !bus.mem_busy) begin
                    grant_d    = win_dma ? 2'b10 : 2'b01;
                    we_d       = sel_we;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    read_en_d  = !sel_we;
                    write_en_d = sel_we;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!bus.mem_busy) begin
                    cpu_ack_d = grant_q[0];
                    dma_ack_d = grant_q[1];
                    if (!we_q) begin
                        if (grant_q[1]) begin
                            dma_rdata_d = bus.mem_rdata;
                        end else begin
                            cpu_rdata_d = bus.mem_rdata;
                        end
                    end
                    state_d = ACK;
                end else if (cnt_inc == TIMEOUT_8) begin
                    cpu_ack_d = grant_q[0];
                    dma_ack_d = grant_q[1];
                    cpu_err_d = grant_q[0];
                    dma_err_d = grant_q[1];
                    if (grant_q[1]) begin
                        dma_rdata_d = 8'h00;
                    end else begin
                        cpu_rdata_d = 8'h00;
                    end
                    cnt_d   = cnt_inc;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ACK: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                // favour whoever did not just finish
                prio_d = grant_q[0];
`endif
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            read_en_q   <= 1'b0;
            write_en_q  <= 1'b0;
            cnt_q       <= 8'd0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dma_err_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            read_en_q   <= read_en_d;
            write_en_q  <= write_en_d;
            cnt_q       <= cnt_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_err_q   <= cpu_err_d;
            dma_err_q   <= dma_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio_q      <= prio_d;
`endif
        end
    end

    assign bus.grant        = grant_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_read_en  = read_en_q;
    assign bus.mem_write_en = write_en_q;
    assign bus.cpu_ack      = cpu_ack_q;
    assign bus.dma_ack      = dma_ack_q;
    assign bus.cpu_err      = cpu_err_q;
    assign bus.dma_err      = dma_err_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.dma_rdata    = dma_rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: stimulus predicts each strobe and ack from the
// arbitration rules and pushes them into queues; a negedge monitor pops and
// compares whenever the DUT strobes memory or acks a requester.
module tb_mem_arb;

    localparam int unsigned TB_TIMEOUT = 5;

    typedef struct packed {
        logic [1:0]  grant;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } strobe_t;

    typedef struct packed {
        logic       is_dma;
        logic       chk_rdata;
        logic       err;
        logic [7:0] rdata;
    } ack_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arb_if bus ();

    mem_arb #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    strobe_t     strobe_q[$];
    ack_t        ack_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_txn   = 0;
    logic [15:0] hold_addr  = 16'h0;
    logic [7:0]  hold_wdata = 8'h0;
    logic        favour_dma;   // model: which requester wins the next tie

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'h0);
        check({tag, "_acks_errs"}, 32'({bus.cpu_ack, bus.dma_ack, bus.cpu_err, bus.dma_err}), 32'h0);
        check({tag, "_strobes"}, 32'({bus.mem_read_en, bus.mem_write_en}), 32'h0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'h0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'h0);
        check({tag, "_rdata"}, 32'({bus.cpu_rdata, bus.dma_rdata}), 32'h0);
    endtask

    task automatic new_req(input bit for_dma);
        if (for_dma) begin
            bus.dma_req   = 1'b1;
            bus.dma_we    = 1'($urandom);
            bus.dma_addr  = 16'($urandom);
            bus.dma_wdata = 8'($urandom);
        end else begin
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'($urandom);
            bus.cpu_addr  = 16'($urandom);
            bus.cpu_wdata = 8'($urandom);
        end
    endtask

    // One transaction: pre busy cycles in IDLE, then b busy WAIT cycles.
    // Called in the first IDLE cycle (#1 after the edge); returns in the ACK cycle.
    task automatic do_txn(input int pre, input int b, input bit drop_early, input logic [7:0] rd);
        bit      wd;
        bit      timed_out;
        strobe_t s;
        ack_t    a;
        int      k;
        int      exp_k;
        bus.mem_busy = (pre > 0);
        repeat (pre) begin
            @(posedge clk); #1;
        end
        bus.mem_busy = 1'b0;
        if (bus.cpu_req && bus.dma_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            wd = favour_dma;
`else
            wd = 1'b0;
`endif
        end else begin
            wd = bus.dma_req;
        end
        timed_out = (b >= int'(TB_TIMEOUT));
        if (wd) s = '{grant: 2'b10, we: bus.dma_we, addr: bus.dma_addr, wdata: bus.dma_wdata};
        else    s = '{grant: 2'b01, we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
        a = '{is_dma: wd, chk_rdata: timed_out || !s.we, err: timed_out, rdata: timed_out ? 8'h00 : rd};
        strobe_q.push_back(s);
        ack_q.push_back(a);
        exp_k = timed_out ? int'(TB_TIMEOUT) + 1 : b + 2;
        @(posedge clk); #1;   // arbitration edge
        check("strobe_latency", 32'(bus.mem_read_en | bus.mem_write_en), 32'h1);
        bus.mem_busy = (b > 0);
        k = 0;
        while (!(bus.cpu_ack || bus.dma_ack) && k < exp_k + 10) begin
            @(posedge clk); #1;
            k++;
            bus.mem_busy  = (k <= b);
            bus.mem_rdata = (k == b + 1) ? rd : 8'($urandom);
            if (drop_early && k == 1) begin
                if (wd) bus.dma_req = 1'b0;
                else    bus.cpu_req = 1'b0;
            end
        end
        check("ack_latency", 32'(k), 32'(exp_k));
        bus.mem_busy = 1'b0;
        if (wd) bus.dma_req = 1'b0;
        else    bus.cpu_req = 1'b0;
        favour_dma = !wd;
        n_txn++;
        $display("[TB] txn %0d: %s %s addr=%h busy=%0d err=%0b", n_txn, wd ? "dma" : "cpu",
                 s.we ? "wr" : "rd", s.addr, b, timed_out);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 && (bus.cpu_req || bus.dma_req); i++) begin
            @(posedge clk); #1;
            do_txn(0, 1, 1'b0, 8'($urandom));
        end
    endtask

    // Monitor: compare every strobe and every ack against the predicted queues
    initial begin
        strobe_t s;
        ack_t    a;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.mem_read_en || bus.mem_write_en) begin
                    if (strobe_q.size() == 0) begin
                        check("unexpected_strobe", 32'({bus.mem_read_en, bus.mem_write_en}), 32'h0);
                    end else begin
                        s = strobe_q.pop_front();
                        check("strobe_kind", 32'({bus.mem_read_en, bus.mem_write_en}), s.we ? 32'h1 : 32'h2);
                        check("strobe_grant", 32'(bus.grant), 32'(s.grant));
                        check("strobe_addr", 32'(bus.mem_addr), 32'(s.addr));
                        if (s.we) check("strobe_wdata", 32'(bus.mem_wdata), 32'(s.wdata));
                        hold_addr  = s.addr;
                        hold_wdata = bus.mem_wdata;
                    end
                end
                if (bus.cpu_ack || bus.dma_ack) begin
                    if (ack_q.size() == 0) begin
                        check("unexpected_ack", 32'({bus.dma_ack, bus.cpu_ack}), 32'h0);
                    end else begin
                        a = ack_q.pop_front();
                        check("ack_owner", 32'({bus.dma_ack, bus.cpu_ack}), a.is_dma ? 32'h2 : 32'h1);
                        check("ack_err", 32'({bus.dma_err, bus.cpu_err}),
                              a.is_dma ? 32'({a.err, 1'b0}) : 32'({1'b0, a.err}));
                        if (a.chk_rdata)
                            check("ack_rdata", 32'(a.is_dma ? bus.dma_rdata : bus.cpu_rdata), 32'(a.rdata));
                        check("ack_grant", 32'(bus.grant), a.is_dma ? 32'h2 : 32'h1);
                        check("ack_addr_held", 32'({bus.mem_addr, bus.mem_wdata}), 32'({hold_addr, hold_wdata}));
                    end
                end else begin
                    check("err_outside_ack", 32'({bus.cpu_err, bus.dma_err}), 32'h0);
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.dma_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.dma_we    = 1'b0;
        bus.cpu_addr  = 16'h0;
        bus.dma_addr  = 16'h0;
        bus.cpu_wdata = 8'h0;
        bus.dma_wdata = 8'h0;
        bus.mem_busy  = 1'b0;
        bus.mem_rdata = 8'h0;
        favour_dma    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Controller busy at release with both requesters waiting: nothing may
        // issue until busy drops; then four tie transactions.
        bus.mem_busy = 1'b1;
        new_req(1'b0);
        new_req(1'b1);
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (!bus.cpu_req) new_req(1'b0);
            if (!bus.dma_req) new_req(1'b1);
            do_txn(i == 0 ? 3 : 0, 0, 1'b0, 8'($urandom));
        end
        drain();

        // CPU read at 0x1234 returning 0xA5 with minimum latency
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'h00;
        do_txn(0, 0, 1'b0, 8'hA5);
        check("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'hA5);

        // DMA write to 0xFFFF, controller busy for 4 cycles after the strobe
        @(posedge clk); #1;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'hFFFF; bus.dma_wdata = 8'h3C;
        do_txn(0, 4, 1'b0, 8'h00);

        // Stuck busy: timeout, then a normal read
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0BAD; bus.cpu_wdata = 8'h00;
        do_txn(0, TB_TIMEOUT + 3, 1'b0, 8'h77);
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001;
        do_txn(0, 1, 1'b0, 8'h5A);

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            int pre;
            int b;
            @(posedge clk); #1;
            if (!bus.cpu_req && $urandom_range(1, 0) == 1) new_req(1'b0);
            if (!bus.dma_req && $urandom_range(1, 0) == 1) new_req(1'b1);
            if (!bus.cpu_req && !bus.dma_req) new_req(1'($urandom));
            pre = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            b   = ($urandom_range(7, 0) == 0) ? int'($urandom_range(TB_TIMEOUT + 2, TB_TIMEOUT))
                                              : int'($urandom_range(TB_TIMEOUT - 1, 0));
            do_txn(pre, b, $urandom_range(3, 0) == 0, 8'($urandom));
        end
        drain();

        // Reset in the middle of WAIT: no ack, everything cleared at once
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hC0DE;
        strobe_q.push_back('{grant: 2'b01, we: 1'b0, addr: 16'hC0DE, wdata: bus.cpu_wdata});
        @(posedge clk); #1;   // ISSUE
        bus.mem_busy = 1'b1;
        @(posedge clk); #1;   // WAIT
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        bus.cpu_req  = 1'b0;
        bus.mem_busy = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_ack_in_reset", 32'({bus.cpu_ack, bus.dma_ack}), 32'h0);
        end
        favour_dma = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h2222;
        do_txn(0, 0, 1'b0, 8'hE1);

        repeat (3) @(posedge clk);
        #1;
        check("strobe_queue_empty", 32'(strobe_q.size()), 32'h0);
        check("ack_queue_empty", 32'(ack_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
